// File: rtl/d_cache_nway_if.sv
// Processor data port and 128-bit line-memory port of the N-way data cache.
// The slave modport is the cache's view; master is the surrounding environment.
interface d_cache_nway_if;
  logic         proc_read_i;
  logic         proc_write_i;
  logic [29:0]  proc_addr_i;
  logic [31:0]  proc_wdata_i;
  logic [31:0]  proc_rdata_o;
  logic         proc_stall_o;
  logic         mem_read_o;
  logic         mem_write_o;
  logic [27:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic [127:0] mem_rdata_i;
  logic         mem_ready_i;

  modport slave (
    input  proc_read_i, proc_write_i, proc_addr_i, proc_wdata_i,
    output proc_rdata_o, proc_stall_o,
    output mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ready_i
  );

  modport master (
    output proc_read_i, proc_write_i, proc_addr_i, proc_wdata_i,
    input  proc_rdata_o, proc_stall_o,
    input  mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ready_i
  );
endinterface

// File: rtl/d_cache_nway.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU
// replacement and saturating hit/miss counters.
module d_cache_nway #(
   parameter int WAYS = 2,
   parameter int SETS = 4
) (
   input  logic          clk,
   input  logic          proc_reset_n_i,
   d_cache_nway_if.slave bus,
   output logic [31:0]   hit_cnt_o,
   output logic [31:0]   miss_cnt_o
);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 28 - IDX_W;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef logic [WAY_W-1:0] way_t;
   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, READY} state_t;

   state_t           state_q, state_d;
   logic             valid_q [SETS][WAYS];
   logic             dirty_q [SETS][WAYS];
   way_t             age_q   [SETS][WAYS];
   logic [TAG_W-1:0] tag_q   [SETS][WAYS];
   logic [127:0]     data_q  [SETS][WAYS];
   way_t             victim_q, victim_sel, hit_way;
   logic [127:0]     fill_q;
   logic [31:0]      hit_cnt_q, miss_cnt_q;

   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic [1:0]       off;
   logic             access, is_write, hit, hit_idle, miss_idle;

   assign idx       = bus.proc_addr_i[IDX_W+1:2];
   assign tag       = bus.proc_addr_i[29:IDX_W+2];
   assign off       = bus.proc_addr_i[1:0];
   assign access    = bus.proc_read_i | bus.proc_write_i;
   assign is_write  = bus.proc_write_i;
   assign hit_idle  = access & hit & (state_q == IDLE);
   assign miss_idle = access & ~hit & (state_q == IDLE);

   assign bus.proc_stall_o = access & ~(hit & (state_q == IDLE));
   assign bus.proc_rdata_o = data_q[idx][hit_way][{off, 5'b0} +: 32];
   assign hit_cnt_o        = hit_cnt_q;
   assign miss_cnt_o       = miss_cnt_q;

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
            hit     = 1'b1;
            hit_way = way_t'(w);
         end
      end
   end

   // Descending loops leave the lowest matching index; an invalid way beats the LRU way.
   always_comb begin
      victim_sel = '0;
      for (int w = WAYS - 1; w >= 0; w--)
         if (age_q[idx][w] == way_t'(WAYS - 1)) victim_sel = way_t'(w);
      for (int w = WAYS - 1; w >= 0; w--)
         if (!valid_q[idx][w]) victim_sel = way_t'(w);
   end

   always_comb begin
      state_d         = state_q;
      bus.mem_read_o  = 1'b0;
      bus.mem_write_o = 1'b0;
      bus.mem_addr_o  = bus.proc_addr_i[29:2];
      bus.mem_wdata_o = data_q[idx][victim_q];
      case (state_q)
         IDLE: begin
            if (miss_idle)
               state_d = (valid_q[idx][victim_sel] && dirty_q[idx][victim_sel]) ? WRITEBACK : ALLOCATE;
         end
         WRITEBACK: begin
            bus.mem_write_o = 1'b1;
            bus.mem_addr_o  = {tag_q[idx][victim_q], idx};
            if (bus.mem_ready_i) state_d = ALLOCATE;
         end
         ALLOCATE: begin
            bus.mem_read_o = 1'b1;
            if (bus.mem_ready_i) state_d = READY;
         end
         READY:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge proc_reset_n_i) begin
      if (!proc_reset_n_i) begin
         state_q    <= IDLE;
         victim_q   <= '0;
         fill_q     <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register update on the same edge, order-independent.
         state_q <= state_d;
         if (miss_idle) begin
            victim_q <= victim_sel;
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
         end
         if (hit_idle && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
         if (state_q == ALLOCATE && bus.mem_ready_i) fill_q <= bus.mem_rdata_i;
      end
   end

   always_ff @(posedge clk or negedge proc_reset_n_i) begin
      if (!proc_reset_n_i) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
               dirty_q[s][w] <= 1'b0;
               age_q[s][w]   <= way_t'(w);
            end
         end
      end else if (hit_idle) begin
         if (is_write) dirty_q[idx][hit_way] <= 1'b1;
         if (WAYS > 1) begin
            for (int w = 0; w < WAYS; w++) begin
               if (way_t'(w) == hit_way)                  age_q[idx][w] <= '0;
               else if (age_q[idx][w] < age_q[idx][hit_way]) age_q[idx][w] <= age_q[idx][w] + way_t'(1);
            end
         end
      end else if (state_q == READY) begin
         valid_q[idx][victim_q] <= 1'b1;
         dirty_q[idx][victim_q] <= 1'b0;
      end
   end

   // NOTE: tag and data arrays are not reset; the valid bits alone decide whether their contents matter.
   always_ff @(posedge clk) begin
      if (hit_idle && is_write) begin
         data_q[idx][hit_way][{off, 5'b0} +: 32] <= bus.proc_wdata_i;
      end else if (state_q == READY) begin
         data_q[idx][victim_q] <= fill_q;
         tag_q[idx][victim_q]  <= tag;
      end
   end
endmodule
